// File: rtl/ntt_delay_pkg.sv
// Shared types, defaults and width helpers for the NTT alignment delay line.
package ntt_delay_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned LANES_DEF     = 1;
    localparam int unsigned MAX_DELAY_DEF = 8;
    localparam int unsigned BUS_W_DEF     = WIDTH_DEF * LANES_DEF;

    // Width needed to hold a delay or count in 0..max_delay
    function automatic int unsigned dw_of(input int unsigned max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Config handshake pulse state
    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_ACK  = 2'd1,
        CFG_ERR  = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/ntt_delay_stage.sv
// One enable-gated {valid, data} pipeline stage; only the valid bit is reset.
module ntt_delay_stage
    import ntt_delay_pkg::*;
#(
    parameter int unsigned BW = BUS_W_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_valid,
    input  logic [BW-1:0] i_data,
    output logic          o_valid,
    output logic [BW-1:0] o_data
);

    logic          r_valid;
    logic [BW-1:0] r_data;

    // Valid bit: synchronous clear wins over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
        end
    end

    // Data payload: no reset, qualified downstream by the valid bit
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ntt_delay_pipe.sv
// Run-time configurable, valid-tracked multi-lane delay line with stall and flush.
module ntt_delay_pipe
    import ntt_delay_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned LANES         = LANES_DEF,
    parameter int unsigned MAX_DELAY     = MAX_DELAY_DEF,
    parameter int unsigned DEFAULT_DELAY = MAX_DELAY_DEF,
    localparam int unsigned DW           = dw_of(MAX_DELAY),
    localparam int unsigned BW           = WIDTH * LANES
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [BW-1:0] din,
    input  logic          cfg_load,
    input  logic [DW-1:0] cfg_delay,
    output logic          cfg_ack,
    output logic          cfg_err,
    output logic          out_valid,
    output logic [BW-1:0] dout,
    output logic [DW-1:0] delay_cur,
    output logic [DW-1:0] inflight,
    output logic          busy
);

    logic [DW-1:0]        r_delay;
    logic [DW-1:0]        r_inflight;
    cfg_state_t           r_state;
    cfg_state_t           w_state_nxt;

    logic                 w_accept;
    logic [DW-1:0]        w_d_eff;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_tap_valid;
    logic [BW-1:0]        w_tap_data;
    logic [MAX_DELAY-1:0] w_stg_vin;
    logic [MAX_DELAY-1:0] w_stg_valid;
    logic [BW-1:0]        w_stg_din  [MAX_DELAY];
    logic [BW-1:0]        w_stg_data [MAX_DELAY];

    // A load is only safe when nothing is in flight, so words never straddle two delays
    assign w_accept = cfg_load & ~flush & (r_inflight == '0) & (cfg_delay <= DW'(MAX_DELAY));
    // Delay that governs the word captured on this edge
    assign w_d_eff  = w_accept ? cfg_delay : r_delay;

    // Stage chain; valid is killed once a word moves past the tap so stale words never resurface
    for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_stg_vin[k] = in_valid & (w_d_eff != '0);
            assign w_stg_din[k] = din;
        end else begin : g_body
            assign w_stg_vin[k] = w_stg_valid[k-1] & (DW'(k) < w_d_eff);
            assign w_stg_din[k] = w_stg_data[k-1];
        end

        ntt_delay_stage #(
            .BW (BW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (en),
            .i_clr   (flush),
            .i_valid (w_stg_vin[k]),
            .i_data  (w_stg_din[k]),
            .o_valid (w_stg_valid[k]),
            .o_data  (w_stg_data[k])
        );
    end

    // Tap mux: select stage delay_cur-1
    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (r_delay == DW'(k + 1)) begin
                w_tap_valid = w_stg_valid[k];
                w_tap_data  = w_stg_data[k];
            end
        end
    end

    // Output select: combinational bypass at zero delay, masked data otherwise
    always_comb begin
        out_valid = w_tap_valid;
        dout      = w_tap_valid ? w_tap_data : '0;
        if (r_delay == '0) begin
            out_valid = in_valid & en;
            dout      = (in_valid & en) ? din : '0;
        end
    end

    assign w_inc = in_valid & (w_d_eff != '0);
    assign w_dec = w_tap_valid & (r_delay != '0);

    // In-flight word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (flush) begin
            r_inflight <= '0;
        end else if (en) begin
            r_inflight <= r_inflight + DW'(w_inc) - DW'(w_dec);
        end
    end

    // Active delay register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay <= DW'(DEFAULT_DELAY);
        end else if (w_accept) begin
            r_delay <= cfg_delay;
        end
    end

    // Config pulse state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config next state and pulse decode
    always_comb begin
        w_state_nxt = CFG_IDLE;
        cfg_ack     = 1'b0;
        cfg_err     = 1'b0;
        if (cfg_load) begin
            w_state_nxt = w_accept ? CFG_ACK : CFG_ERR;
        end
        case (r_state)
            CFG_ACK: cfg_ack = 1'b1;
            CFG_ERR: cfg_err = 1'b1;
            default: ;
        endcase
    end

    assign delay_cur = r_delay;
    assign inflight  = r_inflight;
    assign busy      = (r_inflight != '0);

endmodule

// File: tb/tb_ntt_delay_pipe.sv
// Directed plus randomized check of ntt_delay_pipe against a timestamp-based reference model.
module tb_ntt_delay_pipe;
    import ntt_delay_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LANES = 2;
    localparam int unsigned MAXD  = 8;
    localparam int unsigned DEFD  = 8;
    localparam int unsigned DW    = dw_of(MAXD);
    localparam int unsigned BW    = WIDTH * LANES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] din = '0;
    logic          cfg_load = 1'b0;
    logic [DW-1:0] cfg_delay = '0;
    logic          cfg_ack;
    logic          cfg_err;
    logic          out_valid;
    logic [BW-1:0] dout;
    logic [DW-1:0] delay_cur;
    logic [DW-1:0] inflight;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: each accepted word is stamped with the enabled-cycle count at capture;
    // it is visible at the output while the enabled-cycle count equals stamp + D - 1.
    int            en_cnt;
    int            md;
    logic          m_ack;
    logic          m_err;
    logic [BW-1:0] q_data [$];
    int            q_cap  [$];

    ntt_delay_pipe #(
        .WIDTH         (WIDTH),
        .LANES         (LANES),
        .MAX_DELAY     (MAXD),
        .DEFAULT_DELAY (DEFD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .din       (din),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .out_valid (out_valid),
        .dout      (dout),
        .delay_cur (delay_cur),
        .inflight  (inflight),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        en_cnt = 0;
        md     = DEFD;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        q_data.delete();
        q_cap.delete();
    endtask

    function automatic int m_inflight();
        return (md == 0) ? 0 : q_cap.size();
    endfunction

    function automatic logic m_out_valid();
        if (md == 0) return in_valid & en;
        foreach (q_cap[i]) if (q_cap[i] + md - 1 == en_cnt) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [BW-1:0] m_dout();
        if (md == 0) return (in_valid & en) ? din : '0;
        foreach (q_cap[i]) if (q_cap[i] + md - 1 == en_cnt) return q_data[i];
        return '0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_out_valid()));
        chk({tag, ".dout"},      64'(dout),      64'(m_dout()));
        chk({tag, ".inflight"},  64'(inflight),  64'(m_inflight()));
        chk({tag, ".busy"},      64'(busy),      64'(m_inflight() != 0));
        chk({tag, ".delay_cur"}, 64'(delay_cur), 64'(md));
        chk({tag, ".cfg_ack"},   64'(cfg_ack),   64'(m_ack));
        chk({tag, ".cfg_err"},   64'(cfg_err),   64'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check
    task automatic step(input logic e, input logic f, input logic v, input logic [BW-1:0] d,
                        input logic cl, input logic [DW-1:0] cd, input string tag);
        int  inf;
        int  nd;
        logic acc;
        en = e; flush = f; in_valid = v; din = d; cfg_load = cl; cfg_delay = cd;
        #1;
        if (md == 0) begin
            chk({tag, ".byp_valid"}, 64'(out_valid), 64'(m_out_valid()));
            chk({tag, ".byp_dout"},  64'(dout),      64'(m_dout()));
        end
        inf   = m_inflight();
        acc   = cl && !f && (inf == 0) && (int'(cd) <= MAXD);
        m_ack = cl && acc;
        m_err = cl && !acc;
        if (f) begin
            q_data.delete();
            q_cap.delete();
        end else if (e) begin
            nd = acc ? int'(cd) : md;
            en_cnt++;
            if (v && nd > 0) begin
                q_data.push_back(d);
                q_cap.push_back(en_cnt);
            end
        end
        if (acc) md = int'(cd);
        while (q_cap.size() > 0 && q_cap[0] + md - 1 < en_cnt) begin
            void'(q_cap.pop_front());
            void'(q_data.pop_front());
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, tag);
    endtask

    task automatic do_reset();
        en = 1'b0; flush = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.in.out_valid", 64'(out_valid), 64'(0));
        chk("rst.in.delay_cur", 64'(delay_cur), 64'(DEFD));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst");
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single word, latency 8
        step(1'b1, 1'b0, 1'b1, 32'h0001_0002, 1'b0, '0, "t1.in");
        idle(10, "t1.wait");

        // 20-word stream with a 3-cycle stall mid-stream
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b1, BW'(i), 1'b0, '0, "t2.str");
            if (i == 10) begin
                for (int s = 0; s < 3; s++)
                    step(1'b0, 1'b0, 1'b1, BW'($urandom), 1'b0, '0, "t2.stall");
            end
        end
        idle(10, "t2.drain");

        // Load rejected while busy, accepted once drained
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, BW'(100 + i), 1'b0, '0, "t3.fill");
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, DW'(3), "t3.rej");
        idle(9, "t3.drain");
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, DW'(3), "t3.acc");
        step(1'b1, 1'b0, 1'b1, 32'hCAFE_0003, 1'b0, '0, "t3.word");
        idle(5, "t3.lat");

        // Zero-delay bypass and out-of-range load
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, DW'(0), "t4.acc0");
        for (int i = 0; i < 6; i++)
            step(1'($urandom), 1'b0, 1'($urandom), BW'($urandom), 1'b0, '0, "t4.byp");
        step(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1, DW'(MAXD + 1), "t4.big");
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, DW'(MAXD), "t4.back8");

        // Flush with four words in flight plus a new word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, BW'(200 + i), 1'b0, '0, "t5.fill");
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, DW'(2), "t5.flush");
        idle(12, "t5.after");

        // Randomized traffic with periodic drains and reconfiguration
        for (int i = 0; i < 300; i++) begin
            step(1'(($urandom % 4) != 0), 1'(($urandom % 32) == 0), 1'(($urandom % 4) != 0),
                 BW'($urandom), 1'(($urandom % 16) == 0), DW'($urandom_range(0, 10)), "rnd");
            if (i % 50 == 49) begin
                idle(9, "rnd.drain");
                step(1'b1, 1'b0, 1'($urandom), BW'($urandom), 1'b1,
                     DW'($urandom_range(0, 10)), "rnd.cfg");
            end
        end

        // Async reset restores default delay after a load
        idle(9, "t6.drain");
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, DW'(3), "t6.acc3");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, BW'(300 + i), 1'b0, '0, "t6.str");
        idle(4, "t6.drain3");
        step(1'b1, 1'b0, 1'b1, 32'hABCD_0001, 1'b1, DW'(1), "t6.acc1");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.async.out_valid", 64'(out_valid), 64'(0));
        chk("t6.async.inflight",  64'(inflight),  64'(0));
        chk("t6.async.cfg_ack",   64'(cfg_ack),   64'(0));
        chk("t6.async.delay_cur", 64'(delay_cur), 64'(DEFD));
        en = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("t6.post");
        step(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, '0, "t6.word");
        idle(9, "t6.lat");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_delay_pipe.md
Name: ntt_delay_pipe

Overview:
- Parametrised, multi-lane, valid-tracked delay line for aligning NTT butterfly operands and twiddles across pipeline stages.
- Delay is configurable at run time up to MAX_DELAY, with stall (en), flush and an in-flight counter.
- Sits between the coefficient memory read path and the butterfly units, and anywhere two datapath branches need cycle alignment under back-pressure.

Parameters:
- WIDTH, 16: bits per lane.
- LANES, 1: independent lanes sharing one valid and one delay setting.
- MAX_DELAY, 8: maximum delay in cycles; must be >= 1.
- DEFAULT_DELAY, 8: delay after reset; must be <= MAX_DELAY.
- Derived DW = clog2(MAX_DELAY+1): width of delay and count fields.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; low freezes every stage (stall).
- flush  in  1  synchronous clear of all valid state.
- in_valid  in  1  input word valid.
- din  in  LANES*WIDTH  packed lane data; lane i = din[i*WIDTH +: WIDTH].
- cfg_load  in  1  request to load cfg_delay.
- cfg_delay  in  DW  requested delay, 0..MAX_DELAY.
- cfg_ack  out  1  one-cycle pulse: load accepted.
- cfg_err  out  1  one-cycle pulse: load rejected.
- out_valid  out  1  output word valid.
- dout  out  LANES*WIDTH  delayed data; forced to 0 when out_valid = 0.
- delay_cur  out  DW  active delay.
- inflight  out  DW  number of valid words held in the pipe.
- busy  out  1  inflight != 0.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits, inflight, cfg_ack and cfg_err go to 0.
  - delay_cur goes to DEFAULT_DELAY.
  - Stage data registers are not reset; dout reads 0 because out_valid = 0.
- Stages: stage 0..MAX_DELAY-1, each holding data plus a valid bit.
  - On a clock edge with en = 1 and flush = 0: stage0 <= {in_valid, din} and stage k <= stage k-1.
  - With en = 0, all stages hold.
- Output tap:
  - For D = delay_cur > 0: {out_valid, dout} = stage D-1 (registered; latency exactly D enabled cycles).
  - Words past the tap shift onward and are discarded.
  - For D = 0: combinational bypass, out_valid = in_valid & en, dout = din masked; inflight stays 0.
- Stall: latency is counted in en-high cycles only. out_valid and dout stay stable while en = 0.
- inflight update per edge:
  - flush: clear to 0.
  - Else if en: +1 when in_valid and D > 0; -1 when out_valid and D > 0; both together leave it unchanged.
  - Never exceeds D.
- flush:
  - Has priority over en and in_valid; the in_valid of that cycle is dropped.
  - Next cycle all valid bits and inflight are 0, out_valid = 0 and dout = 0.
- Config handshake, sampled each edge with cfg_load = 1:
  - Accept when inflight == 0, flush = 0, and cfg_delay <= MAX_DELAY. Then delay_cur <= cfg_delay and cfg_ack = 1 for the next cycle.
  - Otherwise delay_cur is unchanged and cfg_err = 1 for the next cycle.
  - A load accepted in the same cycle as in_valid & en: the new word uses the new delay. inflight recounts from 0 with the new D.
  - cfg_load together with flush is rejected (cfg_err).
- cfg_ack and cfg_err are never high together and are registered single pulses.
- Back-to-back cfg_load: each one is evaluated independently.

Decomposition:
- Package ntt_delay_pkg holds:
  - clog2-based width function;
  - localparam default for MAX_DELAY;
  - lane-slice helper constant (WIDTH*LANES).
- One natural sub-module, ntt_delay_stage: a single enable-gated register of {valid, data}, with async-reset valid and no reset on data.
- Top level:
  - generate-chains MAX_DELAY stages;
  - instantiates the tap mux;
  - contains the inflight counter and the config FSM (IDLE/ACK/ERR pulse registers).

Test Plan:
1. Reset, DEFAULT_DELAY = 8, LANES = 2, WIDTH = 16. Drive en = 1, in_valid = 1, din = 0x0001_0002 at cycle 0 only -> out_valid = 1 and dout = 0x0001_0002 at exactly cycle 8; inflight goes 1..1 then 0; busy low at cycle 9.
2. Stream 20 consecutive words (values 1..20), then pull en low for 3 cycles mid-stream -> output order preserved, each word delayed 8 en-cycles, outputs frozen during the stall, inflight steady at 8.
3. With inflight = 5, assert cfg_load with cfg_delay = 3 -> cfg_err pulse, delay_cur stays 8. Drain the pipe, repeat -> cfg_ack pulse, delay_cur = 3, next word latency 3.
4. cfg_delay = 0 accepted -> dout == din in the same cycle, out_valid = in_valid, inflight = 0. cfg_delay = MAX_DELAY+1 -> cfg_err.
5. With 4 words in flight, assert flush together with in_valid -> next cycle out_valid = 0, dout = 0, inflight = 0; no stale word ever emerges; the word presented with flush is never output.
6. Assert rst_n low asynchronously mid-stream between clock edges -> out_valid, inflight and cfg_ack drop immediately; delay_cur returns to 8 even after an earlier load to 3.
